// File: rtl/trace_fmt_pkg.sv
// trace_fmt_pkg: shared definitions for the CPU trace character emitter.
//   - ASCII constants for the fixed punctuation of a trace line
//   - record type codes (register write / memory store)
//   - emitter state enum
//   - hex / decimal digit-to-ASCII helpers
// Optional build macro: TRACE_EMIT_NEWLINE_EN (S_NL is only reached when it is defined).
package trace_fmt_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;  // ^
    localparam logic [7:0] CH_AT     = 8'h40;  // @
    localparam logic [7:0] CH_COLON  = 8'h3A;  // :
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // $
    localparam logic [7:0] CH_STAR   = 8'h2A;  // *
    localparam logic [7:0] CH_LT     = 8'h3C;  // <
    localparam logic [7:0] CH_EQ     = 8'h3D;  // =
    localparam logic [7:0] CH_HASH   = 8'h23;  // #
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_NL     = 8'h0A;

    localparam logic [1:0] TYPE_REG = 2'd1;
    localparam logic [1:0] TYPE_MEM = 2'd2;

    localparam logic [13:0] TIME_MAX = 14'd9999;

    typedef enum logic [4:0] {
        S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SPACE, S_SIGIL,
        S_GRF, S_ADDR, S_SP1, S_LT, S_EQ, S_SP2, S_DATA, S_HASH, S_NL
    } emit_state_e;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        // 'a' - 10 = 8'h57
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

endpackage

// File: rtl/trace_bin2bcd.sv
// trace_bin2bcd: combinational double-dabble, 14-bit binary to four BCD digits.
// Ports:
//   bin_i   [13:0]      binary value (callers keep it <= 9999)
//   bcd_o   [3:0][3:0]  BCD digits, bcd_o[0] is the units digit
//   ndig_o  [2:0]       printed digit count without leading zeros (1..4)
module trace_bin2bcd
    import trace_fmt_pkg::*;
(
    input  logic [13:0]      bin_i,
    output logic [3:0][3:0]  bcd_o,
    output logic [2:0]       ndig_o
);

    logic [29:0] sh;

    always_comb begin
        sh = {16'd0, bin_i};
        for (int i = 0; i < 14; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sh[14 + 4*d +: 4] >= 4'd5)
                    sh[14 + 4*d +: 4] = sh[14 + 4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
    end

    assign bcd_o = sh[29:14];

    always_comb begin
        if (bcd_o[3] != 4'd0)      ndig_o = 3'd4;
        else if (bcd_o[2] != 4'd0) ndig_o = 3'd3;
        else if (bcd_o[1] != 4'd0) ndig_o = 3'd2;
        else                       ndig_o = 3'd1;  // zero still prints "0"
    end

endmodule

// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter: serialises one write-back record into a trace line,
//   "^<time>@<pc>: $<grf> <= <data>#"   (register write)
//   "^<time>@<pc>: *<addr> <= <data>#"  (memory store)
// one ASCII character per char_valid/char_ready handshake.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready + req_type/time/pc/grf/addr/data : record input
//   char/char_valid/char_ready                           : character stream
//   line_done : pulse the cycle after the last character is accepted
//   type_err  : pulse the cycle after an illegal-type record is dropped
// Build macro TRACE_EMIT_NEWLINE_EN: append 8'h0A after '#'.
module cpu_trace_emitter
    import trace_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [13:0] req_time,
    input  logic [31:0] req_pc,
    input  logic [4:0]  req_grf,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [7:0]  char,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        line_done,
    output logic        type_err
);

    emit_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_mem_q;
    logic [13:0] time_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic [4:0]  grf_q;
    logic        line_done_q, type_err_q;

    logic            accept, type_ok, hs, last_hs;
    logic [3:0][3:0] t_bcd, g_bcd;
    logic [2:0]      t_nd, g_nd;
    logic            t_last, g_last, h_last;
    logic [1:0]      t_idx, g_idx;
    logic [31:0]     hex_word;
    logic [3:0]      nib;

    assign type_ok = (req_type == TYPE_REG) || (req_type == TYPE_MEM);
    assign accept  = req_valid && req_ready;
    assign hs      = char_valid && char_ready;

    trace_bin2bcd u_time_bcd (.bin_i(time_q),          .bcd_o(t_bcd), .ndig_o(t_nd));
    trace_bin2bcd u_grf_bcd  (.bin_i({9'd0, grf_q}),   .bcd_o(g_bcd), .ndig_o(g_nd));

    // Counter walks digits MSB first; the digit index counts down from ndig-1.
    assign t_last = (cnt_q == t_nd - 3'd1);
    assign g_last = (cnt_q == g_nd - 3'd1);
    assign h_last = (cnt_q == 3'd7);
    assign t_idx  = t_nd[1:0] - 2'd1 - cnt_q[1:0];
    assign g_idx  = g_nd[1:0] - 2'd1 - cnt_q[1:0];

`ifdef TRACE_EMIT_NEWLINE_EN
    assign last_hs = hs && (state_q == S_NL);
`else
    assign last_hs = hs && (state_q == S_HASH);
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; multi-character states clear the counter on exit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE) begin
            if (accept && type_ok) begin
                state_d = S_CARET;
                cnt_d   = 3'd0;
            end
        end else if (hs) begin
            case (state_q)
                S_CARET: state_d = S_TIME;
                S_TIME:  if (t_last) begin state_d = S_AT; cnt_d = 3'd0; end
                         else cnt_d = cnt_q + 3'd1;
                S_AT:    state_d = S_PC;
                S_PC:    if (h_last) begin state_d = S_COLON; cnt_d = 3'd0; end
                         else cnt_d = cnt_q + 3'd1;
                S_COLON: state_d = S_SPACE;
                S_SPACE: state_d = S_SIGIL;
                S_SIGIL: state_d = is_mem_q ? S_ADDR : S_GRF;
                S_GRF:   if (g_last) begin state_d = S_SP1; cnt_d = 3'd0; end
                         else cnt_d = cnt_q + 3'd1;
                S_ADDR:  if (h_last) begin state_d = S_SP1; cnt_d = 3'd0; end
                         else cnt_d = cnt_q + 3'd1;
                S_SP1:   state_d = S_LT;
                S_LT:    state_d = S_EQ;
                S_EQ:    state_d = S_SP2;
                S_SP2:   state_d = S_DATA;
                S_DATA:  if (h_last) begin state_d = S_HASH; cnt_d = 3'd0; end
                         else cnt_d = cnt_q + 3'd1;
`ifdef TRACE_EMIT_NEWLINE_EN
                S_HASH:  state_d = S_NL;
`else
                S_HASH:  state_d = S_IDLE;
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: char is a pure function of registered state, so it
    // holds still whenever the state is frozen by backpressure.
    always_comb begin
        case (state_q)
            S_PC:    hex_word = pc_q;
            S_ADDR:  hex_word = addr_q;
            default: hex_word = data_q;
        endcase
        nib = hex_word[{~cnt_q, 2'b00} +: 4];

        case (state_q)
            S_CARET: char = CH_CARET;
            S_TIME:  char = dec_char(t_bcd[t_idx]);
            S_AT:    char = CH_AT;
            S_PC, S_ADDR, S_DATA: char = hex_char(nib);
            S_COLON: char = CH_COLON;
            S_SPACE, S_SP1, S_SP2: char = CH_SPACE;
            S_SIGIL: char = is_mem_q ? CH_STAR : CH_DOLLAR;
            S_GRF:   char = dec_char(g_bcd[g_idx]);
            S_LT:    char = CH_LT;
            S_EQ:    char = CH_EQ;
            S_HASH:  char = CH_HASH;
            S_NL:    char = CH_NL;
            default: char = 8'h00;
        endcase
        char_valid = (state_q != S_IDLE);
        req_ready  = (state_q == S_IDLE);
    end

    // Record capture; time saturates here so the BCD path never sees > 9999.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_mem_q <= 1'b0;
            time_q   <= 14'd0;
            pc_q     <= 32'd0;
            grf_q    <= 5'd0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
        end else if (accept && type_ok) begin
            is_mem_q <= (req_type == TYPE_MEM);
            time_q   <= (req_time > TIME_MAX) ? TIME_MAX : req_time;
            pc_q     <= req_pc;
            grf_q    <= req_grf;
            addr_q   <= req_addr;
            data_q   <= req_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_done_q <= 1'b0;
            type_err_q  <= 1'b0;
        end else begin
            line_done_q <= last_hs;
            type_err_q  <= accept && !type_ok;
        end
    end

    assign line_done = line_done_q;
    assign type_err  = type_err_q;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: table of records with their literal expected
// lines; expected characters are queued when a record is driven and popped
// by a monitor on every character handshake.
module tb_cpu_trace_emitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready;
    logic [1:0]  req_type;
    logic [13:0] req_time;
    logic [31:0] req_pc, req_addr, req_data;
    logic [4:0]  req_grf;
    logic [7:0]  char;
    logic        char_valid, char_ready;
    logic        line_done, type_err;

    cpu_trace_emitter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_time(req_time), .req_pc(req_pc), .req_grf(req_grf),
        .req_addr(req_addr), .req_data(req_data),
        .char(char), .char_valid(char_valid), .char_ready(char_ready),
        .line_done(line_done), .type_err(type_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [13:0] tm;
        logic [31:0] pc;
        logic [4:0]  grf;
        logic [31:0] addr;
        logic [31:0] data;
        bit          stall;
        string       exp;
    } vec_t;

    typedef struct {
        logic [7:0] c;
        bit         last;
    } exp_t;

    exp_t q[$];
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, chars_seen = 0, last_hs_cyc = -100, gap = 0;
    bit   stall_en = 1'b0, prev_stall = 1'b0, prev_cv = 1'b0;
    logic [7:0] prev_char = 8'h00;
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic vec_t mk(input logic [1:0] t, input logic [13:0] tm,
                                input logic [31:0] pc, input logic [4:0] g,
                                input logic [31:0] a, input logic [31:0] d,
                                input bit st, input string s);
        vec_t v;
        v.typ = t; v.tm = tm; v.pc = pc; v.grf = g;
        v.addr = a; v.data = d; v.stall = st; v.exp = s;
        return v;
    endfunction

    function automatic int line_len(input string s);
`ifdef TRACE_EMIT_NEWLINE_EN
        return s.len() + 1;
`else
        return s.len();
`endif
    endfunction

    task automatic push_line(input string s);
        exp_t e;
        for (int k = 0; k < s.len(); k++) begin
            e.c = s[k];
            e.last = 1'b0;
`ifndef TRACE_EMIT_NEWLINE_EN
            if (k == s.len() - 1) e.last = 1'b1;
`endif
            q.push_back(e);
        end
`ifdef TRACE_EMIT_NEWLINE_EN
        e.c = 8'h0A;
        e.last = 1'b1;
        q.push_back(e);
`endif
    endtask

    task automatic drive_fields(input vec_t v);
        req_type = v.typ; req_time = v.tm; req_pc = v.pc;
        req_grf = v.grf; req_addr = v.addr; req_data = v.data;
    endtask

    task automatic scramble;
        req_type = 2'd1; req_time = 14'h3fff; req_pc = 32'hdead_0000;
        req_grf = 5'd17; req_addr = 32'h5555_aaaa; req_data = 32'h0bad_f00d;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin @(negedge clk); n++; end
        if (!req_ready) fail_now("wait_idle");
    endtask

    // Drive one record and check the whole line plus its timing.
    task automatic send(input vec_t v);
        int  n;
        bit  done;
        wait_idle();
        push_line(v.exp);
        stall_en = v.stall;
        @(posedge clk); #1;
        drive_fields(v);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        scramble();
        n = 0; done = 1'b0;
        while (n < 2000 && !done) begin @(negedge clk); n++; done = line_done; end
        if (!done) fail_now("line_done_wait");
        else if (!v.stall) check("line_cycles", n, line_len(v.exp) + 1);
        @(negedge clk);
        check("line_done_pulse", line_done, 1'b0);
        #1;
        check("queue_empty", q.size(), 0);
        stall_en = 1'b0;
    endtask

    task automatic send_bad(input logic [1:0] t);
        wait_idle();
        @(posedge clk); #1;
        req_type = t;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("type_err_hi", type_err, 1'b1);
        check("bad_no_char", char_valid, 1'b0);
        check("bad_ready", req_ready, 1'b1);
        @(negedge clk);
        check("type_err_pulse", type_err, 1'b0);
        check("bad_no_char2", char_valid, 1'b0);
    endtask

    initial begin
        char_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            char_ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expected character per handshake, checks hold during stalls.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_stall) check("stall_hold", {char_valid, char}, {1'b1, prev_char});
            if (char_valid) check("req_ready_busy", req_ready, 1'b0);
            if (char_valid && char == 8'h5E && !prev_cv) gap = cyc - last_hs_cyc;
            if (char_valid && char_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_char: got %0h expected none", char);
                end else begin
                    mon_e = q.pop_front();
                    check("char", char, mon_e.c);
                    if (mon_e.last) last_hs_cyc = cyc;
                    chars_seen++;
                end
            end
            prev_stall = char_valid && !char_ready;
            prev_char  = char;
            prev_cv    = char_valid;
        end else begin
            prev_stall = 1'b0;
            prev_cv    = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    vec_t tbl[6];
    vec_t fresh, va, vb;

    initial begin
        int n, base;
        req_valid = 1'b0;
        scramble();
        #1 reset = 1'b0;

        tbl[0] = mk(2'd1, 14'd5,     32'h0000_3000, 5'd8,  32'h0,          32'h0000_abcd, 1'b0,
                    "^5@00003000: $8 <= 0000abcd#");
        tbl[1] = mk(2'd2, 14'd1234,  32'h0000_3004, 5'd0,  32'h0000_0010,  32'hffff_ffff, 1'b0,
                    "^1234@00003004: *00000010 <= ffffffff#");
        tbl[2] = mk(2'd1, 14'd0,     32'h0,         5'd0,  32'h0,          32'h0,         1'b1,
                    "^0@00000000: $0 <= 00000000#");
        tbl[3] = mk(2'd1, 14'd12000, 32'h1234_5678, 5'd31, 32'h0,          32'hdead_beef, 1'b0,
                    "^9999@12345678: $31 <= deadbeef#");
        tbl[4] = mk(2'd2, 14'd10,    32'h89ab_cdef, 5'd3,  32'hcafe_0001,  32'h0,         1'b1,
                    "^10@89abcdef: *cafe0001 <= 00000000#");
        tbl[5] = mk(2'd1, 14'd100,   32'h0000_ffff, 5'd10, 32'h0,          32'h0102_0304, 1'b0,
                    "^100@0000ffff: $10 <= 01020304#");

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_char", char, 8'h00);
        check("rst_char_valid", char_valid, 1'b0);
        check("rst_line_done", line_done, 1'b0);
        check("rst_type_err", type_err, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        @(posedge clk); #2 reset = 1'b1;

        for (int i = 0; i < 6; i++) send(tbl[i]);

        // Illegal types are dropped
        send_bad(2'd3);
        send_bad(2'd0);

        // Reset mid-line after 10 accepted characters
        wait_idle();
        push_line("^42@00000100: $3 <= 00000001#");
        base = chars_seen;
        @(posedge clk); #1;
        req_type = 2'd1; req_time = 14'd42; req_pc = 32'h100;
        req_grf = 5'd3; req_data = 32'h1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (chars_seen < base + 10 && n < 500) begin @(negedge clk); #1; n++; end
        if (chars_seen < base + 10) fail_now("ten_chars_wait");
        @(posedge clk); #2 reset = 1'b0;
        #1;
        check("async_rst_char_valid", char_valid, 1'b0);
        check("async_rst_req_ready", req_ready, 1'b1);
        q.delete();
        @(negedge clk); #2 reset = 1'b1;
        fresh = mk(2'd2, 14'd9, 32'h400, 5'd0, 32'h20, 32'h1234_5678, 1'b0,
                   "^9@00000400: *00000020 <= 12345678#");
        send(fresh);

        // Back-to-back records with req_valid held high
        va = mk(2'd1, 14'd77, 32'h0000_3008, 5'd1, 32'h0, 32'h0000_0077, 1'b0,
                "^77@00003008: $1 <= 00000077#");
        vb = mk(2'd2, 14'd78, 32'h0000_300c, 5'd0, 32'h0000_0040, 32'ha5a5_5a5a, 1'b0,
                "^78@0000300c: *00000040 <= a5a55a5a#");
        wait_idle();
        push_line(va.exp);
        push_line(vb.exp);
        @(posedge clk); #1;
        drive_fields(va);
        req_valid = 1'b1;
        @(posedge clk); #1;
        drive_fields(vb);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin @(negedge clk); n++; end
        if (!req_ready) fail_now("b2b_ready_wait");
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!line_done && n < 500) begin @(negedge clk); n++; end
        if (!line_done) fail_now("b2b_done_wait");
        check("b2b_gap", gap, 2);
        #1;
        check("b2b_queue_empty", q.size(), 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
